// File: rtl/irq_arbiter.sv
// irq_arbiter: synchronised multi-source interrupt controller with priority arbitration
// and a claim/complete register port.
module irq_arbiter #(
  parameter int N_SRC = 8,
  parameter int PRIO_W = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic [5:0]        reg_addr,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              irq_out,
  output logic [4:0]        irq_id
);
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q, edge_pend, enable, mode, in_service;
  logic [N_SRC-1:0] synced, rise, pending, elig, clr, claim_mask, cmp_mask;
  logic [N_SRC-1:0] mode_n, edge_pend_n, in_service_n;
  logic [PRIO_W-1:0] prio [N_SRC];
  logic [PRIO_W-1:0] threshold, best_p;
  logic [4:0] best_id;
  logic [31:0] rd_val;
  logic claim, cmp_wr, unused;
  assign unused = ^reg_wdata[31:N_SRC];
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise = synced & ~prev_q;
  assign pending = (mode & edge_pend) | (~mode & synced);
  assign elig = pending & enable & ~in_service;
  assign claim = reg_rd && reg_addr == 6'h04 && irq_id != '0;
  assign cmp_wr = reg_wr && reg_addr == 6'h04;
  assign mode_n = (reg_wr && reg_addr == 6'h01) ? reg_wdata[N_SRC-1:0] : mode;
  assign clr = claim_mask | ((reg_wr && reg_addr == 6'h02) ? reg_wdata[N_SRC-1:0] : '0);
  // set wins over clear; level-mode sources never hold latched pending
  assign edge_pend_n = ((edge_pend & ~clr) | rise) & mode_n;
  assign in_service_n = (in_service & ~cmp_mask) | claim_mask;
  always_comb begin
    best_p = '0;
    best_id = '0;
    claim_mask = '0;
    cmp_mask = '0;
    case (reg_addr)
      6'h00:   rd_val = 32'(enable);
      6'h01:   rd_val = 32'(mode);
      6'h02:   rd_val = 32'(pending);
      6'h03:   rd_val = 32'(threshold);
      6'h04:   rd_val = 32'(irq_id);
      6'h05:   rd_val = 32'(in_service);
      default: rd_val = '0;
    endcase
    for (int i = 0; i < N_SRC; i++) begin
      if (elig[i] && prio[i] > threshold && prio[i] > best_p) begin
        best_p = prio[i];
        best_id = 5'(i + 1);
      end
      claim_mask[i] = claim && irq_id == 5'(i + 1);
      cmp_mask[i] = cmp_wr && reg_wdata[4:0] == 5'(i + 1);
      if (reg_addr == 6'(16 + i)) rd_val = 32'(prio[i]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      prev_q <= '0;
      edge_pend <= '0;
      enable <= '0;
      mode <= '0;
      in_service <= '0;
      threshold <= '0;
      reg_rdata <= '0;
      irq_id <= '0;
      irq_out <= 1'b0;
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= synced;
      edge_pend <= edge_pend_n;
      mode <= mode_n;
      in_service <= in_service_n;
      if (reg_wr && reg_addr == 6'h00) enable <= reg_wdata[N_SRC-1:0];
      if (reg_wr && reg_addr == 6'h03) threshold <= reg_wdata[PRIO_W-1:0];
      for (int i = 0; i < N_SRC; i++) if (reg_wr && reg_addr == 6'(16 + i)) prio[i] <= reg_wdata[PRIO_W-1:0];
      if (reg_rd) reg_rdata <= rd_val;
      irq_id <= best_id;
      irq_out <= best_id != '0 && in_service == '0;
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed test-plan scenarios plus random traffic, scored against a reference model.
module tb_irq_arbiter;
  localparam int N = 8, SS = 2, PW = 3;
  logic clk = 0, reset = 1, reg_wr = 0, reg_rd = 0;
  logic [N-1:0] irq_src = '0;
  logic [5:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic irq_out;
  logic [4:0] irq_id;
  int n_cmp = 0, n_bad = 0;

  irq_arbiter #(.N_SRC(N), .PRIO_W(PW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .irq_out(irq_out), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: source history queue, per-source pending/in-service sets
  logic [N-1:0] hist [SS];
  logic [N-1:0] m_prev, m_pe, m_ena, m_mode, m_ins;
  logic [N-1:0] syn, rise, pend, clr, clm, cmp, nmode;
  int m_thr, m_id, best, bp, wid, a;
  int m_prio [N];
  bit m_out;
  logic [5:0] q_irq [$];
  logic [31:0] q_rd [$];
  logic [5:0] e_irq;

  function automatic logic [31:0] m_read(int ad);
    logic [N-1:0] p;
    p = (m_mode & m_pe) | (~m_mode & hist[SS-1]);
    if (ad == 0) return 32'(m_ena);
    if (ad == 1) return 32'(m_mode);
    if (ad == 2) return 32'(p);
    if (ad == 3) return 32'(m_thr);
    if (ad == 4) return 32'(m_id);
    if (ad == 5) return 32'(m_ins);
    if (ad >= 16 && ad < 16 + N) return 32'(m_prio[ad-16]);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SS; s++) hist[s] = '0;
      for (int i = 0; i < N; i++) m_prio[i] = 0;
      m_prev = '0; m_pe = '0; m_ena = '0; m_mode = '0; m_ins = '0;
      m_thr = 0; m_id = 0; m_out = 0;
      q_irq.push_back(6'd0);
    end else begin
      a = int'(reg_addr);
      syn = hist[SS-1];
      rise = syn & ~m_prev;
      pend = (m_mode & m_pe) | (~m_mode & syn);
      if (reg_rd) q_rd.push_back(m_read(a));
      best = 0; bp = 0;
      for (int i = 0; i < N; i++)
        if (pend[i] && m_ena[i] && !m_ins[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
          bp = m_prio[i];
          best = i + 1;
        end
      clm = '0;
      if (reg_rd && a == 4 && m_id != 0) clm[m_id-1] = 1'b1;
      cmp = '0;
      wid = int'(reg_wdata[4:0]);
      if (reg_wr && a == 4 && wid >= 1 && wid <= N && m_ins[wid-1]) cmp[wid-1] = 1'b1;
      clr = clm;
      nmode = m_mode;
      if (reg_wr) begin
        if (a == 0) m_ena = reg_wdata[N-1:0];
        if (a == 1) nmode = reg_wdata[N-1:0];
        if (a == 2) clr = clr | reg_wdata[N-1:0];
        if (a == 3) m_thr = int'(reg_wdata[PW-1:0]);
        if (a >= 16 && a < 16 + N) m_prio[a-16] = int'(reg_wdata[PW-1:0]);
      end
      m_out = best != 0 && m_ins == '0;
      m_id = best;
      m_pe = ((m_pe & ~clr) | rise) & nmode;
      m_mode = nmode;
      m_ins = (m_ins & ~cmp) | clm;
      m_prev = syn;
      for (int s = SS - 1; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = irq_src;
      q_irq.push_back({m_out, 5'(m_id)});
    end
  end

  always @(negedge clk) begin
    if (q_irq.size() != 0) begin
      e_irq = q_irq.pop_front();
      chk("irq_id", 32'(irq_id), 32'(e_irq[4:0]));
      chk("irq_out", 32'(irq_out), 32'(e_irq[5]));
    end
    if (q_rd.size() != 0) chk("reg_rdata", reg_rdata, q_rd.pop_front());
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(int ad, logic [31:0] d);
    reg_wr = 1; reg_addr = 6'(ad); reg_wdata = d;
    step();
    reg_wr = 0;
  endtask

  task automatic rd(int ad);
    reg_rd = 1; reg_addr = 6'(ad);
    step();
    reg_rd = 0;
  endtask

  task automatic pulse(logic [N-1:0] v);
    irq_src = v;
    step();
    irq_src = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset irq_out", 32'(irq_out), 0);
    chk("reset irq_id", 32'(irq_id), 0);
    chk("reset rdata", reg_rdata, 0);
    reset = 0;
    // basic edge source, 3-edge latency, claim
    wr(0, 1); wr(16, 3); wr(1, 1);
    pulse(8'h01);
    step(); chk("t1 out@1", 32'(irq_out), 0);
    step(); chk("t1 out@2", 32'(irq_out), 0);
    step(); chk("t1 out@3", 32'(irq_out), 1); chk("t1 id@3", 32'(irq_id), 1);
    rd(4); chk("t1 claim", reg_rdata, 1);
    step(); chk("t1 out after claim", 32'(irq_out), 0);
    rd(2); chk("t1 pending", reg_rdata, 0);
    // tie-break and priority change
    do_reset();
    wr(0, 32'h12); wr(1, 32'h12); wr(17, 4); wr(20, 4);
    pulse(8'h12); idle(4);
    chk("t2 tie id", 32'(irq_id), 2);
    wr(20, 6); step();
    chk("t2 prio id", 32'(irq_id), 5);
    // threshold
    wr(20, 4); wr(3, 4); idle(2);
    chk("t3 thr4 out", 32'(irq_out), 0);
    wr(3, 3); idle(2);
    chk("t3 thr3 out", 32'(irq_out), 1);
    // level source
    do_reset();
    wr(0, 32'h04); wr(18, 2); wr(1, 0);
    irq_src = 8'h04; idle(4);
    chk("t4 lvl out", 32'(irq_out), 1);
    rd(4); chk("t4 claim", reg_rdata, 3);
    idle(2); chk("t4 in service out", 32'(irq_out), 0);
    wr(4, 3); idle(2);
    chk("t4 complete out", 32'(irq_out), 1);
    irq_src = '0; idle(4);
    chk("t4 released id", 32'(irq_id), 0);
    // re-arm during service, wrong complete
    do_reset();
    wr(0, 1); wr(16, 3); wr(1, 1);
    pulse(8'h01); idle(4);
    rd(4);
    pulse(8'h01); idle(4);
    chk("t5 queued out", 32'(irq_out), 0);
    wr(4, 4); idle(2);
    chk("t5 wrong id out", 32'(irq_out), 0);
    wr(4, 1); idle(2);
    chk("t5 rearm out", 32'(irq_out), 1);
    chk("t5 rearm id", 32'(irq_id), 1);
    // reset mid-claim
    do_reset();
    wr(0, 1); wr(16, 3); wr(1, 1);
    pulse(8'h01); idle(4);
    rd(4); rd(5);
    #2 reset = 1;
    #1 chk("t6 async out", 32'(irq_out), 0);
    chk("t6 async id", 32'(irq_id), 0);
    chk("t6 async rdata", reg_rdata, 0);
    step(); reset = 0;
    rd(4); chk("t6 claim after reset", reg_rdata, 0);
    // random traffic
    do_reset();
    wr(0, 32'hff); wr(1, 32'h0f);
    for (int i = 0; i < N; i++) wr(16 + i, $urandom_range(1, 7));
    repeat (3000) begin
      int r, ad;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) irq_src[i] = ~irq_src[i];
      r = $urandom_range(0, 9);
      ad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) :
           ($urandom_range(0, 1) == 0) ? $urandom_range(0, 5) : 16 + $urandom_range(0, N - 1);
      if (r < 3 || r == 9) begin reg_rd = 1; reg_addr = 6'(r == 9 ? 4 : ad); end
      if ((r >= 3 && r < 5) || r == 9) begin
        reg_wr = 1;
        reg_addr = 6'(r == 9 ? 4 : ad);
        reg_wdata = (reg_addr == 6'h04) ? 32'($urandom_range(0, 10)) :
                    (reg_addr == 6'h00 && $urandom_range(0, 3) != 0) ? 32'hff : $urandom();
      end
      if (r == 5) begin reg_rd = 1; reg_addr = 6'h04; end
      step();
      reg_rd = 0; reg_wr = 0;
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Parametrised multi-source interrupt controller in front of the core's CSR/interrupt unit. It replaces the single raw interrupt line with N synchronised sources. Each source has per-source edge/level mode, enable, and priority, plus a global threshold. It drives one registered request to the core and exposes a claim/complete handshake through a word-addressed register port on the data-memory bus, mapped like the LED/UART peripherals.

## Interface
Parameters:
- N_SRC, 8: number of interrupt sources, 1..31; source IDs are 1..N_SRC, and ID 0 means "none".
- PRIO_W, 3: priority width; priority 0 means never interrupt.
- SYNC_STAGES, 2: synchroniser depth per source, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- irq_src  in  N_SRC  raw asynchronous interrupt lines; bit i maps to ID i+1.
- reg_addr  in  6  word address.
- reg_wr  in  1  register write strobe, single cycle.
- reg_rd  in  1  register read strobe, single cycle.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- irq_out  out  1  interrupt request to the core's interrupt input, registered.
- irq_id  out  5  ID of the current best candidate (0 if none), registered.

## Operation
Register map (word addresses):
- 0x00 ENABLE[N_SRC-1:0], RW.
- 0x01 MODE, RW; 1 = edge, 0 = level.
- 0x02 PENDING, RO for level sources; write-1-to-clear for edge sources.
- 0x03 THRESHOLD[PRIO_W-1:0], RW.
- 0x04 CLAIM/COMPLETE: a read claims; a write completes.
- 0x05 IN_SERVICE, RO.
- 0x10+i PRIO of ID i+1, RW, PRIO_W bits. Addresses 0x10+N_SRC..0x3F read 0.
- Unmapped reads return 0; unmapped writes are ignored.

Behaviour:
- Synchronisation: each irq_src bit passes through a SYNC_STAGES flip-flop chain. A further register holds the previous synchronised value for edge detection.
- Pending, edge mode: set on a synchronised rising edge; cleared by claim or W1C. If a set and a clear occur in the same cycle, set wins.
- Pending, level mode: equals the synchronised level and is not latched. A claim does not clear it.
- Eligibility: pending & ENABLE & ~IN_SERVICE & (PRIO > THRESHOLD).
- Arbitration: highest PRIO among eligible sources; ties go to the lowest ID. The result is registered into irq_id each cycle.
- irq_out = (irq_id != 0) & (IN_SERVICE == 0). Operation is single-level and non-nesting.
- Claim: a reg_rd at 0x04 returns the current irq_id. If it is nonzero, the same edge sets IN_SERVICE for that ID and clears its edge-pending bit. A claim returning 0 changes no state.
- Complete: a reg_wr at 0x04 with wdata[4:0] = ID clears IN_SERVICE for that ID. A write with an ID not in service, 0, or > N_SRC is ignored.
- Edge re-arm: an edge arriving on an in-service edge source sets pending again (one queued event); further edges are merged.
- Mode change: writing MODE while pending clears the pending bits of sources switching to level mode.
- Reset: all registers go to 0, including synchronisers, ENABLE, MODE, PRIO, THRESHOLD, PENDING, IN_SERVICE, reg_rdata, irq_out and irq_id. Asserting reset mid-claim abandons the claim with no residual state.

## Timing
- Source-to-request latency: irq_src rising before edge k gives pending set at edge k+SYNC_STAGES and irq_id/irq_out updated at edge k+SYNC_STAGES+1. With the default of 2, irq_out rises 3 edges after the source.
- Reads: reg_rd at edge k gives reg_rdata valid after edge k, for one cycle. reg_rdata holds its value otherwise.
- Claim side effects: they take effect at the same edge as the read. irq_out deasserts at edge k+1 (registered), so the core sees at most one extra request cycle.
- Complete side effects: IN_SERVICE clears at the write edge, and irq_out may reassert at the next edge.
- Simultaneous reg_rd and reg_wr: the write is applied and the read returns pre-write data. A claim and a complete in the same cycle are both applied.

## Test plan
1. Reset, then ENABLE=0x01, PRIO1=3, MODE=1, pulse irq_src[0] for 1 cycle -> irq_out=1 and irq_id=1 exactly 3 cycles after the pulse; read 0x04 -> 1; PENDING=0; irq_out=0 the next cycle.
2. IDs 2 and 5 edge-pending with PRIO 4 and 4 -> irq_id=2; set PRIO5=6 -> irq_id=5 after 1 cycle.
3. THRESHOLD=4 with a PRIO=4 source pending -> irq_out stays 0; THRESHOLD=3 -> irq_out=1.
4. Level source ID 3 held high: claim returns 3, and irq_out=0 while in service; complete 3 -> irq_out=1 again. Release the line, then 2 sync cycles -> irq_id=0.
5. Edge source claimed, second pulse during service, complete with the wrong ID 4 -> no change; complete with ID 1 -> irq_out reasserts with irq_id=1.
6. Assert reset mid-claim (IN_SERVICE=0x01) -> all outputs 0 immediately; after release, a claim read returns 0.
